// File: rtl/lms_coef_update.sv
// LMS weight-update engine for a 9-tap FIR: serial per-tap update into a working bank,
// then an atomic copy to the published coefficient bank.
module lms_coef_update #(
  parameter int unsigned        MU_SHIFT  = 12,
  parameter logic signed [15:0] COEF_INIT = 16'sd0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               sample_valid_i,
  input  logic signed [15:0] data_in,
  input  logic               err_valid_i,
  input  logic signed [15:0] err_i,
  input  logic               freeze_i,
  input  logic               clr_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               drop_o,
  output logic               sat_o,
  output logic signed [15:0] coef1,
  output logic signed [15:0] coef2,
  output logic signed [15:0] coef3,
  output logic signed [15:0] coef4,
  output logic signed [15:0] coef5,
  output logic signed [15:0] coef6,
  output logic signed [15:0] coef7,
  output logic signed [15:0] coef8,
  output logic signed [15:0] coef9
);

  localparam int unsigned DW = 16;
  localparam int unsigned NT = 9;
  localparam int unsigned KW = 4;
  localparam int unsigned PW = 32;
  localparam int unsigned SW = 33;

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [KW-1:0]        r_k;
  logic signed [DW-1:0] r_x    [NT];
  logic signed [DW-1:0] r_snap [NT];
  logic signed [DW-1:0] r_work [NT];
  logic signed [DW-1:0] r_act  [NT];
  logic signed [DW-1:0] r_e;
  logic                 r_sat_acc;

  logic                 w_accept;
  logic                 w_drop;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_delta;
  logic signed [SW-1:0] w_sum;
  logic signed [DW-1:0] w_upd;
  logic                 w_clamp;

  // Next-state and accept/drop decode; clear overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    if (clr_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (err_valid_i && !freeze_i) begin
            w_accept    = 1'b1;
            w_state_nxt = S_UPD;
          end
        end
        S_UPD:   if (r_k == KW'(NT - 1)) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
      w_drop = (r_state != S_IDLE) && err_valid_i && !freeze_i;
    end
  end

  // Per-tap update: floor-shifted product added in 33 bits, then clamped to 16
  always_comb begin
    w_prod  = $signed(PW'(r_snap[r_k])) * $signed(PW'(r_e));
    w_delta = w_prod >>> MU_SHIFT;
    w_sum   = $signed(SW'(r_work[r_k])) + $signed(SW'(w_delta));
    w_upd   = w_sum[DW-1:0];
    w_clamp = 1'b0;
    if (w_sum > $signed(SW'(32767))) begin
      w_upd   = 16'sh7FFF;
      w_clamp = 1'b1;
    end else if (w_sum < $signed(-SW'(32768))) begin
      w_upd   = 16'sh8000;
      w_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_k       <= '0;
      r_e       <= '0;
      r_sat_acc <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      drop_o    <= 1'b0;
      sat_o     <= 1'b0;
      for (int i = 0; i < NT; i++) begin
        r_x[i]    <= '0;
        r_snap[i] <= '0;
        r_work[i] <= COEF_INIT;
        r_act[i]  <= COEF_INIT;
      end
    end else begin
      // Tap history shifts independently of any update pass
      if (sample_valid_i) begin
        for (int i = NT - 1; i > 0; i--) r_x[i] <= r_x[i-1];
        r_x[0] <= data_in;
      end
      busy_o <= (w_state_nxt != S_IDLE);
      done_o <= (r_state == S_DONE) && !clr_i;
      sat_o  <= (r_state == S_DONE) && !clr_i && r_sat_acc;
      drop_o <= w_drop;
      if (clr_i) begin
        r_sat_acc <= 1'b0;
        for (int i = 0; i < NT; i++) begin
          r_work[i] <= COEF_INIT;
          r_act[i]  <= COEF_INIT;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_e       <= err_i;
              r_k       <= '0;
              r_sat_acc <= 1'b0;
              for (int i = 0; i < NT; i++) begin
                r_snap[i] <= r_x[i];
                r_work[i] <= r_act[i];
              end
            end
          end
          S_UPD: begin
            r_work[r_k] <= w_upd;
            r_sat_acc   <= r_sat_acc | w_clamp;
            r_k         <= r_k + KW'(1);
          end
          S_DONE: begin
            for (int i = 0; i < NT; i++) r_act[i] <= r_work[i];
          end
          default: ;
        endcase
      end
    end
  end

  assign coef1 = r_act[0];
  assign coef2 = r_act[1];
  assign coef3 = r_act[2];
  assign coef4 = r_act[3];
  assign coef5 = r_act[4];
  assign coef6 = r_act[5];
  assign coef7 = r_act[6];
  assign coef8 = r_act[7];
  assign coef9 = r_act[8];

endmodule

// File: tb/tb_lms_coef_update.sv
// Directed bench for lms_coef_update; two instances share stimulus (MU_SHIFT 12 and 0).
module tb_lms_coef_update;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               sample_valid_i;
  logic signed [15:0] data_in;
  logic               err_valid_i;
  logic signed [15:0] err_i;
  logic               freeze_i;
  logic               clr_i;

  logic               busy_o, done_o, drop_o, sat_o;
  logic               busy0, done0, drop0, sat0;
  logic signed [15:0] ca [9];
  logic signed [15:0] cb [9];

  int n_chk = 0;
  int n_err = 0;

  int busy_first, n_done, n_drop, done_cyc, sat_seen;

  always #5 clk_i = ~clk_i;

  lms_coef_update #(.MU_SHIFT(12), .COEF_INIT(16'sd0)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sample_valid_i(sample_valid_i), .data_in(data_in),
    .err_valid_i(err_valid_i), .err_i(err_i), .freeze_i(freeze_i), .clr_i(clr_i),
    .busy_o(busy_o), .done_o(done_o), .drop_o(drop_o), .sat_o(sat_o),
    .coef1(ca[0]), .coef2(ca[1]), .coef3(ca[2]), .coef4(ca[3]), .coef5(ca[4]),
    .coef6(ca[5]), .coef7(ca[6]), .coef8(ca[7]), .coef9(ca[8])
  );

  lms_coef_update #(.MU_SHIFT(0), .COEF_INIT(16'sd0)) u_dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sample_valid_i(sample_valid_i), .data_in(data_in),
    .err_valid_i(err_valid_i), .err_i(err_i), .freeze_i(freeze_i), .clr_i(clr_i),
    .busy_o(busy0), .done_o(done0), .drop_o(drop0), .sat_o(sat0),
    .coef1(cb[0]), .coef2(cb[1]), .coef3(cb[2]), .coef4(cb[3]), .coef5(cb[4]),
    .coef6(cb[5]), .coef7(cb[6]), .coef8(cb[7]), .coef9(cb[8])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int exp);
    for (int i = 0; i < 9; i++) check($sformatf("%s_coef%0d", tag, i + 1), int'(ca[i]), exp);
  endtask

  task automatic push(input int v);
    @(negedge clk_i);
    sample_valid_i = 1'b1;
    data_in        = 16'(v);
    @(negedge clk_i);
    sample_valid_i = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 9; i++) push(v);
  endtask

  task automatic clear();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
  endtask

  // Issue one error sample, then watch a fixed 14-cycle window; optional mid-pass events
  task automatic run_pass(input int e, input int drop_at, input int clr_at, input bit shift);
    @(negedge clk_i);
    err_valid_i = 1'b1;
    err_i       = 16'(e);
    @(negedge clk_i);
    err_valid_i = 1'b0;
    busy_first  = int'(busy_o);
    n_done = 0; n_drop = 0; done_cyc = -1; sat_seen = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      err_valid_i    = (cyc == drop_at);
      clr_i          = (cyc == clr_at);
      sample_valid_i = shift && (cyc >= 2) && (cyc <= 10);
      data_in        = 16'sd0;
      @(negedge clk_i);
      err_valid_i    = 1'b0;
      clr_i          = 1'b0;
      sample_valid_i = 1'b0;
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
        sat_seen = int'(sat_o);
      end
      if (drop_o) n_drop++;
    end
  endtask

  initial begin
    rst_n_i = 1'b0; sample_valid_i = 1'b0; data_in = '0; err_valid_i = 1'b0;
    err_i = '0; freeze_i = 1'b0; clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_drop", int'(drop_o), 0);
    check("rst_sat", int'(sat_o), 0);
    check_all("rst", 0);
    rst_n_i = 1'b1;

    // 1: basic update, latency and no saturation
    fill(4096);
    run_pass(4096, -1, -1, 1'b0);
    check("t1_busy", busy_first, 1);
    check("t1_lat", done_cyc, 10);
    check("t1_ndone", n_done, 1);
    check("t1_sat", sat_seen, 0);
    check("t1_idle", int'(busy_o), 0);
    check_all("t1", 4096);

    // 2: tap order with MU_SHIFT=0
    clear();
    for (int v = 1; v <= 9; v++) push(v);
    run_pass(2, -1, -1, 1'b0);
    for (int i = 0; i < 9; i++) check($sformatf("t2_coef%0d", i + 1), int'(cb[i]), 2 * (9 - i));
    check_all("t2_mu12", 0);

    // 3: positive and negative saturation
    clear();
    fill(32767);
    run_pass(32767, -1, -1, 1'b0);
    check("t3_sat_pos", sat_seen, 1);
    check_all("t3_pos", 32767);
    run_pass(-32768, -1, -1, 1'b0);
    check("t3_sat_neg", sat_seen, 1);
    check_all("t3_neg", -32768);

    // 4: arithmetic shift floors toward -inf
    clear();
    fill(-1);
    run_pass(1, -1, -1, 1'b0);
    check("t4_sat", sat_seen, 0);
    check_all("t4", -1);

    // 5: error while busy is dropped; freeze blocks accept
    clear();
    fill(4096);
    run_pass(4096, 3, -1, 1'b0);
    check("t5_ndrop", n_drop, 1);
    check("t5_ndone", n_done, 1);
    check_all("t5", 4096);
    freeze_i = 1'b1;
    @(negedge clk_i);
    err_valid_i = 1'b1;
    @(negedge clk_i);
    err_valid_i = 1'b0;
    check("t5_frz_busy", int'(busy_o), 0);
    check("t5_frz_drop", int'(drop_o), 0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (done_o || busy_o) n_done++;
    end
    check("t5_frz_idle", n_done, 0);
    freeze_i = 1'b0;
    check_all("t5_frz", 4096);

    // 6: clear aborts a pass; mid-pass shifting does not disturb the snapshot
    run_pass(4096, -1, 5, 1'b0);
    check("t6_clr_ndone", n_done, 0);
    check("t6_clr_busy", int'(busy_o), 0);
    check_all("t6_clr", 0);
    fill(4096);
    run_pass(4096, -1, -1, 1'b1);
    check("t6_snap_ndone", n_done, 1);
    check_all("t6_snap", 4096);
    run_pass(4096, -1, -1, 1'b0);
    check("t6_zero_ndone", n_done, 1);
    check_all("t6_zero", 4096);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
